// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory arbiter: port indices and word geometry.
package mem_arb_pkg;
   localparam logic PORT_D     = 1'b0;
   localparam logic PORT_I     = 1'b1;
   localparam int   STRB_W     = 4;
   localparam int   WORD_SHIFT = 2;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the port that did not win last time is granted.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt,
   output logic       last
);

   logic r_last;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_last <= PORT_I;
      end else if (accept) begin
         r_last <= gnt[PORT_I];
      end
   end

   always_comb begin
      gnt         = 2'b00;
      gnt[PORT_D] = req[PORT_D] & (~req[PORT_I] | (r_last == PORT_I));
      gnt[PORT_I] = req[PORT_I] & (~req[PORT_D] | (r_last == PORT_D));
   end

   assign last = r_last;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read RAM between the data and instruction-fetch ports,
// one access per cycle, response returned on the owning port one cycle later.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MEM_AW = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic                d_req_we,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic [DATA_W-1:0]   d_req_wdata,
   input  logic [DATA_W/8-1:0] d_req_wstrb,
   output logic                d_resp_valid,
   output logic [DATA_W-1:0]   d_resp_rdata,
   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [ADDR_W-1:0]   i_req_addr,
   output logic                i_resp_valid,
   output logic [DATA_W-1:0]   i_resp_rdata,
   output logic                mem_en,
   output logic [STRB_W-1:0]   mem_we,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   logic [1:0] w_req;
   logic [1:0] w_gnt;
   logic       w_last;
   logic       w_gnt_d;
   logic       w_gnt_i;
   logic       w_accept;
   logic       w_unused;

   logic       r_pend;
   logic       r_pend_port;
   logic       r_pend_we;

   assign w_req[PORT_D] = d_req_valid;
   assign w_req[PORT_I] = i_req_valid;

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rst    (rst),
      .req    (w_req),
      .accept (w_accept),
      .gnt    (w_gnt),
      .last   (w_last)
   );

   // Reset masks every grant so nothing reaches the RAM while rst is low.
   assign w_gnt_d  = rst & w_gnt[PORT_D];
   assign w_gnt_i  = rst & w_gnt[PORT_I];
   assign w_accept = w_gnt_d | w_gnt_i;

   assign d_req_ready = w_gnt_d;
   assign i_req_ready = w_gnt_i;

   always_comb begin
      mem_en    = w_accept;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_gnt_d) begin
         mem_addr  = d_req_addr[WORD_SHIFT+MEM_AW-1:WORD_SHIFT];
         mem_wdata = d_req_wdata;
         if (d_req_we) begin
            mem_we = d_req_wstrb;
         end
      end else if (w_gnt_i) begin
         mem_addr = i_req_addr[WORD_SHIFT+MEM_AW-1:WORD_SHIFT];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pend      <= 1'b0;
         r_pend_port <= PORT_D;
         r_pend_we   <= 1'b0;
      end else begin
         r_pend      <= w_accept;
         r_pend_port <= w_gnt_i ? PORT_I : PORT_D;
         r_pend_we   <= w_gnt_d & d_req_we;
      end
   end

   // A response pending across a reset cycle is dropped by the rst gating here.
   assign d_resp_valid = rst & r_pend & (r_pend_port == PORT_D);
   assign i_resp_valid = rst & r_pend & (r_pend_port == PORT_I);
   assign d_resp_rdata = (d_resp_valid && !r_pend_we) ? mem_rdata : '0;
   assign i_resp_rdata = i_resp_valid ? mem_rdata : '0;

   // Byte offset and aliased upper address bits are intentionally dropped.
   assign w_unused = &{1'b0, w_last,
                       d_req_addr[WORD_SHIFT-1:0], d_req_addr[ADDR_W-1:WORD_SHIFT+MEM_AW],
                       i_req_addr[WORD_SHIFT-1:0], i_req_addr[ADDR_W-1:WORD_SHIFT+MEM_AW]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (fair alternation under contention, word-addressed memory).
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        d_req_valid;
   logic        d_req_ready;
   logic        d_req_we;
   logic [31:0] d_req_addr;
   logic [31:0] d_req_wdata;
   logic [3:0]  d_req_wstrb;
   logic        d_resp_valid;
   logic [31:0] d_resp_rdata;
   logic        i_req_valid;
   logic        i_req_ready;
   logic [31:0] i_req_addr;
   logic        i_resp_valid;
   logic [31:0] i_resp_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_AW(14)) dut (
      .clk          (clk),
      .rst          (rst),
      .d_req_valid  (d_req_valid),
      .d_req_ready  (d_req_ready),
      .d_req_we     (d_req_we),
      .d_req_addr   (d_req_addr),
      .d_req_wdata  (d_req_wdata),
      .d_req_wstrb  (d_req_wstrb),
      .d_resp_valid (d_resp_valid),
      .d_resp_rdata (d_resp_rdata),
      .i_req_valid  (i_req_valid),
      .i_req_ready  (i_req_ready),
      .i_req_addr   (i_req_addr),
      .i_resp_valid (i_resp_valid),
      .i_resp_rdata (i_resp_rdata),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-first synchronous RAM seen by the DUT.
   logic [31:0] ram [0:16383];
   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
         mem_rdata <= ram[mem_addr];
      end
   end

   // Reference model state: expected memory contents, who was served last, and
   // the one outstanding response.
   logic [31:0] ref_mem [0:16383];
   int          n_checks;
   int          n_pass;
   logic        m_last_was_i;
   logic        m_pend;
   logic        m_pend_i;
   logic [31:0] m_data;
   logic        g_acc_d;
   logic        g_acc_i;
   logic [31:0] obs_d_rdata;
   logic [13:0] obs_addr;
   int          n_i_resp;
   int          n_d_resp;

   function automatic logic [31:0] init_word(input int k);
      return 32'hA500_0000 ^ (k * 32'h0001_0101);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %h, want %h", tag, obs, exp);
      else n_pass++;
   endtask

   // One clock of checking: combinational outputs and responses at the falling
   // edge, then the model advances on the rising edge.
   task automatic step();
      logic ed, ei, exp_dv, exp_iv;
      int   w;
      @(negedge clk);
      ed = 1'b0;
      ei = 1'b0;
      if (rst) begin
         if (d_req_valid && i_req_valid) begin
            ed = m_last_was_i;
            ei = !m_last_was_i;
         end else begin
            ed = d_req_valid;
            ei = i_req_valid;
         end
      end
      check_eq("d_ready", {31'd0, d_req_ready}, {31'd0, ed});
      check_eq("i_ready", {31'd0, i_req_ready}, {31'd0, ei});
      check_eq("mem_en", {31'd0, mem_en}, {31'd0, ed | ei});
      check_eq("mem_we", {28'd0, mem_we}, (ed && d_req_we) ? {28'd0, d_req_wstrb} : 32'd0);
      if (ed) begin
         check_eq("mem_addr_d", {18'd0, mem_addr}, {18'd0, d_req_addr[15:2]});
         check_eq("mem_wdata_d", mem_wdata, d_req_wdata);
      end else if (ei) begin
         check_eq("mem_addr_i", {18'd0, mem_addr}, {18'd0, i_req_addr[15:2]});
         check_eq("mem_wdata_i", mem_wdata, 32'd0);
      end else if (!rst) begin
         check_eq("mem_addr_rst", {18'd0, mem_addr}, 32'd0);
         check_eq("mem_wdata_rst", mem_wdata, 32'd0);
      end
      exp_dv = rst && m_pend && !m_pend_i;
      exp_iv = rst && m_pend && m_pend_i;
      check_eq("d_resp_valid", {31'd0, d_resp_valid}, {31'd0, exp_dv});
      check_eq("i_resp_valid", {31'd0, i_resp_valid}, {31'd0, exp_iv});
      check_eq("d_resp_rdata", d_resp_rdata, exp_dv ? m_data : 32'd0);
      check_eq("i_resp_rdata", i_resp_rdata, exp_iv ? m_data : 32'd0);
      if (d_resp_valid) n_d_resp++;
      if (i_resp_valid) n_i_resp++;
      obs_d_rdata = d_resp_rdata;
      obs_addr    = mem_addr;
      g_acc_d     = ed;
      g_acc_i     = ei;
      @(posedge clk);
      if (!rst) begin
         m_pend       = 1'b0;
         m_last_was_i = 1'b1;
      end else begin
         m_pend   = ed | ei;
         m_pend_i = ei;
         if (ed) begin
            w = int'(d_req_addr[15:2]);
            if (d_req_we) begin
               for (int b = 0; b < 4; b++)
                  if (d_req_wstrb[b]) ref_mem[w][8*b +: 8] = d_req_wdata[8*b +: 8];
               m_data = 32'd0;
            end else begin
               m_data = ref_mem[w];
            end
         end
         if (ei) m_data = ref_mem[int'(i_req_addr[15:2])];
         if (ed || ei) m_last_was_i = ei;
      end
      #1;
   endtask

   task automatic set_d(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s);
      d_req_valid = v;
      d_req_we    = we;
      d_req_addr  = a;
      d_req_wdata = wd;
      d_req_wstrb = s;
   endtask

   task automatic rand_d();
      set_d($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3)),
            $urandom, 4'($urandom_range(0, 15)));
   endtask

   task automatic rand_i();
      i_req_valid = ($urandom_range(0, 3) != 0);
      i_req_addr  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 63)) << 2);
   endtask

   logic [31:0] d_a;
   logic [31:0] i_a;
   int          n_i_acc;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_i_resp = 0;
      n_d_resp = 0;
      m_last_was_i = 1'b1;
      m_pend   = 1'b0;
      m_pend_i = 1'b0;
      m_data   = 32'd0;
      mem_rdata = 32'd0;
      for (int k = 0; k < 16384; k++) begin
         ram[k]     = init_word(k);
         ref_mem[k] = init_word(k);
      end
      ram[16]     = 32'h1122_3344;
      ref_mem[16] = 32'h1122_3344;

      // Reset held with both requesters active.
      rst = 1'b0;
      set_d(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
      i_req_valid = 1'b1;
      i_req_addr  = 32'h100;
      repeat (3) step();

      // Sustained contention: first grant after reset goes to D, then alternate.
      rst = 1'b1;
      d_a = 32'h200;
      i_a = 32'h100;
      for (int c = 0; c < 8; c++) begin
         step();
         if (c == 0) check_eq("first_grant_d", {31'd0, g_acc_d}, 32'd1);
         if (g_acc_d) d_a += 4;
         if (g_acc_i) i_a += 4;
         d_req_addr = d_a;
         i_req_addr = i_a;
      end
      check_eq("contend_d_addr", d_a, 32'h210);
      check_eq("contend_i_addr", i_a, 32'h110);
      set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      i_req_valid = 1'b0;
      step();

      // Partial store then load of the same word, back to back.
      set_d(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011);
      step();
      set_d(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      step();
      check_eq("store_ack_rdata", obs_d_rdata, 32'd0);
      set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();
      check_eq("store_load_rdata", obs_d_rdata, 32'h1122_BEEF);

      // Upper address bits alias, byte offset ignored.
      set_d(1'b1, 1'b0, 32'h0001_0004, 32'h0, 4'h0);
      step();
      check_eq("alias_addr", {18'd0, obs_addr}, 32'd1);
      d_req_addr = 32'h0001_0007;
      step();
      check_eq("alias_addr_off", {18'd0, obs_addr}, 32'd1);
      set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();

      // Lone fetch stream.
      n_i_resp = 0;
      n_d_resp = 0;
      n_i_acc  = 0;
      for (int c = 0; c < 5; c++) begin
         i_req_valid = 1'b1;
         i_req_addr  = 32'(c * 4);
         step();
         if (g_acc_i) n_i_acc++;
      end
      i_req_valid = 1'b0;
      step();
      check_eq("lone_i_accepts", n_i_acc, 32'd5);
      check_eq("lone_i_resps", n_i_resp, 32'd5);
      check_eq("lone_d_silent", n_d_resp, 32'd0);

      // Reset right after a D load is accepted: its response must vanish.
      i_req_valid = 1'b1;
      i_req_addr  = 32'h300;
      step();
      i_req_valid = 1'b0;
      set_d(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
      step();
      set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      n_d_resp = 0;
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      check_eq("rst_drop_resp", n_d_resp, 32'd0);
      set_d(1'b1, 1'b0, 32'h84, 32'h0, 4'h0);
      i_req_valid = 1'b1;
      step();
      check_eq("rst_last_is_i", {31'd0, g_acc_d}, 32'd1);

      // Random traffic with requesters honouring the hold-until-ready rule.
      rand_d();
      rand_i();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 49) != 0);
         step();
         if (!d_req_valid || g_acc_d) rand_d();
         if (!i_req_valid || g_acc_i) rand_i();
      end
      rst = 1'b1;
      set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      i_req_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
